// File: rtl/arb_mux.sv
// N-channel round-robin / fixed-priority arbiter feeding a single registered output slot.
// Optional ARB_MUX_FORCE_SEL_EN adds force_en/force_sel to override arbitration with a fixed channel.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 18,
  parameter int RR    = 1,
  parameter int SW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_sel,
  input  logic                 out_ready
`ifdef ARB_MUX_FORCE_SEL_EN
  ,
  input  logic                 force_en,
  input  logic [SW-1:0]        force_sel
`endif
);

  logic [SW-1:0]    ptr_p0;
  logic             gnt_vld_p0;
  logic [SW-1:0]    gnt_p0;
  logic             ptr_upd_p0;
  logic             load_p0;
  logic             xfer_p0;
  logic [WIDTH-1:0] gnt_data_p0;
  int               idx;

  // Stage p0: combinational grant from in_valid and the rotating pointer
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_p0     = '0;
    ptr_upd_p0 = (RR != 0);
    idx        = 0;
    // Scan from the far end so the candidate closest to ptr is written last and wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (RR != 0) begin
        idx = int'(ptr_p0) + k;
        if (idx >= N) idx = idx - N;
      end else begin
        idx = k;
      end
      if (in_valid[idx]) begin
        gnt_vld_p0 = 1'b1;
        gnt_p0     = SW'(idx);
      end
    end
`ifdef ARB_MUX_FORCE_SEL_EN
    if (force_en) begin
      ptr_upd_p0 = 1'b0;
      gnt_p0     = force_sel;
      gnt_vld_p0 = (int'(force_sel) < N) ? in_valid[force_sel] : 1'b0;
    end
`endif
  end

  assign load_p0     = !out_valid || out_ready;
  assign xfer_p0     = load_p0 && gnt_vld_p0;
  assign gnt_data_p0 = in_data[gnt_p0*WIDTH +: WIDTH];

  always_comb begin
    in_ready = '0;
    if (xfer_p0 && !rst) in_ready[gnt_p0] = 1'b1;
  end

  // Stage p1: output slot and pointer advance on each accepted transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr_p0    <= '0;
    end else if (load_p0) begin
      out_valid <= gnt_vld_p0;
      if (gnt_vld_p0) begin
        out_data <= gnt_data_p0;
        out_sel  <= gnt_p0;
        if (ptr_upd_p0) ptr_p0 <= (int'(gnt_p0) == N - 1) ? '0 : gnt_p0 + 1'b1;
      end
    end
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits of every channel, WIDTH >= 1.
REQ-002 Parameter N, default 18: number of input channels, 2 <= N <= 32.
REQ-003 Parameter RR, default 1: arbitration mode, 1 = round-robin, 0 = fixed priority (lowest index wins).
REQ-004 Parameter SW, default $clog2(N): width of channel index fields.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  N  per-channel request; bit i qualifies channel i.
REQ-008 in_data  input  N*WIDTH  channel i data occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_ready  output  N  per-channel accept; one-hot or zero.
REQ-010 out_valid  output  1  output register holds valid data.
REQ-011 out_data  output  WIDTH  registered data of the granted channel.
REQ-012 out_sel  output  SW  index of the channel whose data is in out_data.
REQ-013 out_ready  input  1  downstream accept of out_data.

Function
REQ-014 load = !out_valid | out_ready; a transfer on channel i occurs when in_valid[i] & in_ready[i] at a rising edge.
REQ-015 in_ready[i] SHALL be 1 only when load = 1 and channel i is the grant; at most one in_ready bit high per cycle.
REQ-016 Grant SHALL be combinational from in_valid and the priority pointer; no grant when in_valid = 0.
REQ-017 RR = 0: grant = lowest index i with in_valid[i] = 1; pointer unused.
REQ-018 RR = 1: grant = first i with in_valid[i] = 1 searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
REQ-019 RR = 1: on a transfer from channel g, ptr SHALL become g+1, or 0 if g = N-1; ptr unchanged otherwise.
REQ-020 On a transfer, out_data <= in_data of g, out_sel <= g, out_valid <= 1, one-cycle latency.
REQ-021 When load = 1 and no in_valid, out_valid <= 0 at the edge; out_data/out_sel hold.
REQ-022 When out_valid = 1 and out_ready = 0, out_data, out_sel, out_valid and ptr SHALL hold; all in_ready = 0.
REQ-023 Simultaneous out_ready and new grant SHALL sustain one transfer per cycle (no bubble).
REQ-024 in_valid deasserting without a transfer SHALL not change ptr or outputs.
REQ-025 Round-robin SHALL be starvation-free: a held in_valid[i] is granted within N transfers.

Reset
REQ-026 While rst = 1: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0, in_ready = 0, asynchronously.
REQ-027 Reset mid-transfer SHALL discard the output register contents; first edge after release behaves as empty.

Configuration
REQ-028 Macro ARB_MUX_FORCE_SEL_EN, when defined, adds ports force_en (input, 1) and force_sel (input, SW).
REQ-029 With macro and force_en = 1: grant = force_sel if in_valid[force_sel] = 1, else no grant; ptr not updated.
REQ-030 With macro and force_sel >= N while force_en = 1: no grant, no transfer.
REQ-031 Without macro: ports absent, arbitration per REQ-017..019 only.

Verification
REQ-032 N=4, RR=1, out_ready=1, in_valid=4'b1111 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; one transfer per cycle.
REQ-033 N=4, RR=0, in_valid=4'b1010 held, out_ready=1 -> out_sel = 1 every cycle; in_ready[3] never high.
REQ-034 Transfer from channel 2 (data 0xDEADBEEF) then out_ready=0 for 3 cycles -> out_data holds 0xDEADBEEF, out_valid=1, in_ready=0.
REQ-035 N=18, RR=1, ptr=17, in_valid bits 17 and 0 set -> grant 17, then ptr wraps to 0, next grant 0.
REQ-036 rst pulsed between clock edges while out_valid=1 -> out_valid=0, out_sel=0, ptr=0 immediately; next grant from channel 0 first.
REQ-037 ARB_MUX_FORCE_SEL_EN defined, force_en=1, force_sel=5, in_valid=all ones -> out_sel = 5 each cycle, ptr unchanged.
